// File: rtl/epb_ctrl_pkg.sv
// epb_ctrl_pkg: FSM state encodings and shared constants for the EPB slave controller.
package epb_ctrl_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_RDY  = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;
   localparam logic [15:0] EPB_DEAD_WORD = 16'hDEAD;
   localparam int EPB_SYNC_STAGES = 2;
endpackage

// File: rtl/epb_sync_ff.sv
// epb_sync_ff: multi-flop synchroniser for asynchronous EPB strobes, resets to 1 (strobe inactive).
module epb_sync_ff
   import epb_ctrl_pkg::*;
#(
   parameter int STAGES = EPB_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sr;
   always_ff @(posedge clk)
      if (rst) sr <= '1;
      else sr <= {sr[STAGES-2:0], d};
   assign q = sr[STAGES-1];
endmodule

// File: rtl/epb_slave_ctrl.sv
// epb_slave_ctrl: EPB slave sequencer bridging pad-buffer strobes to a req/ack register bus.
// Optional ack-wait timeout is built only when EPB_TIMEOUT_EN is defined.
module epb_slave_ctrl
   import epb_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 23,
   parameter int GP_W    = 6,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                   epb_clk,
   input  logic                   epb_rst,
   input  logic                   epb_cs_n,
   input  logic                   epb_oe_n,
   input  logic                   epb_r_w_n,
   input  logic [1:0]             epb_be_n,
   input  logic [ADDR_W-1:0]      epb_addr,
   input  logic [GP_W-1:0]        epb_addr_gp,
   input  logic [DATA_W-1:0]      epb_data_in_i,
   output logic [DATA_W-1:0]      epb_data_out_o,
   output logic                   epb_data_oe_n_o,
   output logic                   epb_rdy,
   output logic                   epb_rdy_oe,
   output logic                   bus_req_o,
   output logic                   bus_we_o,
   output logic [GP_W+ADDR_W-1:0] bus_addr_o,
   output logic [1:0]             bus_be_o,
   output logic [DATA_W-1:0]      bus_wdata_o,
   input  logic [DATA_W-1:0]      bus_rdata_i,
   input  logic                   bus_ack_i,
   output logic                   bus_timeout_o
);
   logic cs_s, oe_s, rw_s;
   logic [2:0] state, nxt;
   logic abort_q, aborted, tmo, done;

   epb_sync_ff u_cs (.clk(epb_clk), .rst(epb_rst), .d(epb_cs_n),  .q(cs_s));
   epb_sync_ff u_oe (.clk(epb_clk), .rst(epb_rst), .d(epb_oe_n),  .q(oe_s));
   epb_sync_ff u_rw (.clk(epb_clk), .rst(epb_rst), .d(epb_r_w_n), .q(rw_s));

`ifdef EPB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge epb_clk)
      cnt <= (epb_rst || state != ST_WAIT) ? '0 : cnt + 1'b1;
   // a same-cycle ack wins over the timeout
   assign tmo = state == ST_WAIT && !bus_ack_i && cnt == CW'(TIMEOUT - 1);
`else
   logic unused_timeout;
   assign unused_timeout = TIMEOUT != 0;
   assign tmo = 1'b0;
`endif

   // an abort is remembered until the pending ack wait drains back to IDLE
   assign aborted = abort_q | (cs_s & (state == ST_REQ || state == ST_WAIT));
   assign done    = bus_ack_i | tmo;

   always_ff @(posedge epb_clk)
      if (epb_rst) state <= ST_IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: nxt = cs_s ? ST_IDLE : ST_REQ;
         ST_REQ:  nxt = ST_WAIT;
         ST_WAIT: nxt = !done ? ST_WAIT : aborted ? ST_IDLE : ST_RDY;
         ST_RDY:  nxt = ST_HOLD;
         ST_HOLD: nxt = cs_s ? ST_IDLE : ST_HOLD;
         default: nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus_req_o       = state == ST_REQ;
      epb_rdy         = state == ST_RDY || state == ST_HOLD;
      epb_rdy_oe      = state != ST_IDLE && !aborted;
      epb_data_oe_n_o = !(epb_rdy && !bus_we_o && !oe_s);
      bus_timeout_o   = tmo;
   end

   always_ff @(posedge epb_clk)
      if (epb_rst) begin
         bus_addr_o     <= '0;
         bus_be_o       <= '0;
         bus_wdata_o    <= '0;
         bus_we_o       <= 1'b0;
         epb_data_out_o <= '0;
         abort_q        <= 1'b0;
      end else begin
         if (state == ST_IDLE && !cs_s) begin
            bus_addr_o  <= {epb_addr_gp, epb_addr};
            bus_be_o    <= ~epb_be_n;
            bus_wdata_o <= epb_data_in_i;
            bus_we_o    <= ~rw_s;
         end
         abort_q <= state == ST_IDLE ? 1'b0 : aborted;
         if (state == ST_WAIT && bus_ack_i) epb_data_out_o <= bus_rdata_i;
         else if (tmo) epb_data_out_o <= DATA_W'(EPB_DEAD_WORD);
      end
endmodule
